// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared types and helpers for the single-port SRAM initiator controller.
package ct_f_spsram_ctrl_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic int unsigned sram_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/ct_f_spsram_init_seq.sv
// Post-reset sweep: writes INIT_VALUE to every entry, one address per cycle while en_i.
// done_o pulses on the cycle the last address is driven.
module ct_f_spsram_init_seq
   import ct_f_spsram_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 9,
   parameter int                    DATA_WIDTH = 7,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   output logic [ADDR_WIDTH-1:0] a_o,
   output logic                  cen_o,
   output logic                  gwen_o,
   output logic [DATA_WIDTH-1:0] wen_o,
   output logic [DATA_WIDTH-1:0] d_o,
   output logic                  done_o
);

   localparam int            CW   = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] LAST = CW'(sram_depth(ADDR_WIDTH) - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign cnt_d = en_i ? cnt_q + CW'(1) : cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign a_o    = cnt_q[ADDR_WIDTH-1:0];
   assign cen_o  = ~en_i;
   assign gwen_o = ~en_i;
   assign wen_o  = en_i ? '0 : '1;
   assign d_o    = INIT_VALUE;
   assign done_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ct_f_spsram_ctrl.sv
// Valid/ready front end for a ct_f_spsram_* macro (active-low CEN/GWEN/WEN, 1-cycle read).
// Define CT_F_SPSRAM_CTRL_INIT_EN to sweep the array to INIT_VALUE after reset.
module ct_f_spsram_ctrl
   import ct_f_spsram_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 9,
   parameter int                    DATA_WIDTH = 7,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_bmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] A,
   output logic                  CEN,
   output logic                  GWEN,
   output logic [DATA_WIDTH-1:0] WEN,
   output logic [DATA_WIDTH-1:0] D,
   input  logic [DATA_WIDTH-1:0] Q
);

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
   localparam state_e RST_STATE = INIT;
`else
   localparam state_e RST_STATE = RUN;
`endif

   state_e                  state_q, state_d;
   logic                    init_done_q, init_done_d;
   logic                    rsp_vld_q, rsp_vld_d;
   logic [ADDR_WIDTH-1:0]   a_q;
   logic [DATA_WIDTH-1:0]   d_q;
   logic                    acc, rd_acc;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
   logic                    sweep_en, seq_done, sw_cen, sw_gwen;
   logic [ADDR_WIDTH-1:0]   sw_a;
   logic [DATA_WIDTH-1:0]   sw_wen, sw_d;

   // Gated by RST so the pins show idle values while reset is held.
   assign sweep_en = (state_q == INIT) && !RST;

   ct_f_spsram_init_seq #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .INIT_VALUE (INIT_VALUE)
   ) u_init_seq (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (sweep_en),
      .a_o    (sw_a),
      .cen_o  (sw_cen),
      .gwen_o (sw_gwen),
      .wen_o  (sw_wen),
      .d_o    (sw_d),
      .done_o (seq_done)
   );
`else
   logic unused_init_value;
   assign unused_init_value = ^INIT_VALUE;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= RST_STATE;
         init_done_q <= 1'b0;
         rsp_vld_q   <= 1'b0;
         a_q         <= '0;
         d_q         <= '0;
      end else begin
         state_q     <= state_d;
         init_done_q <= init_done_d;
         rsp_vld_q   <= rsp_vld_d;
         a_q         <= A;
         d_q         <= D;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
         INIT:    if (seq_done) state_d = RUN;
`else
         INIT:    state_d = RUN;
`endif
         RUN:     state_d = RUN;
         default: state_d = RST_STATE;
      endcase
   end

   assign init_done_d = init_done_q | (state_d == RUN);

   // A stalled response blocks new requests: CEN stays high so Q holds.
   assign req_rdy   = (state_q == RUN) && init_done_q && !(rsp_vld_q && !rsp_rdy);
   assign acc       = req_vld && req_rdy;
   assign rd_acc    = acc && !req_wr;
   assign rsp_vld_d = rd_acc || (rsp_vld_q && !rsp_rdy);

   assign rsp_vld   = rsp_vld_q;
   assign rsp_rdata = Q;
   assign init_done = init_done_q;

   // Idle cycles hold A/D at their last values to avoid toggling.
   always_comb begin
      A    = a_q;
      D    = d_q;
      CEN  = 1'b1;
      GWEN = 1'b1;
      WEN  = '1;
      if (acc) begin
         A   = req_addr;
         CEN = 1'b0;
         if (req_wr) begin
            GWEN = 1'b0;
            WEN  = ~req_bmask;
            D    = req_wdata;
         end else begin
            D    = '0;
         end
      end
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
      if (sweep_en) begin
         A    = sw_a;
         D    = sw_d;
         CEN  = sw_cen;
         GWEN = sw_gwen;
         WEN  = sw_wen;
      end
`endif
   end

endmodule
